// File: rtl/sel_datapath_pipe.sv
// sel_datapath_pipe: two-stage, C-band-selected datapath (CNT/SHIFT/ACC/PASS) with valid/ready.
// Define SDP_OVF_FLAG_EN to add the sticky ovf output (counter wrap / accumulator saturation).
`timescale 1ns/1ps

module sel_datapath_pipe #(
  parameter int A_W     = 10,
  parameter int C_W     = 9,
  parameter int OUT_W   = A_W + 1,
  parameter int SH_LO   = 51,
  parameter int ACC_LO  = 100,
  parameter int PASS_LO = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   A,
  input  logic [C_W-1:0]   C,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out
`ifdef SDP_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int SH_W  = $clog2(OUT_W);
  localparam int SUM_W = OUT_W + 1;
  localparam logic [C_W-1:0] SH_C   = C_W'(SH_LO);
  localparam logic [C_W-1:0] ACC_C  = C_W'(ACC_LO);
  localparam logic [C_W-1:0] PASS_C = C_W'(PASS_LO);

  typedef enum logic [1:0] {
    M_CNT,
    M_SHIFT,
    M_ACC,
    M_PASS
  } mode_e;

  mode_e            mode_d;
  mode_e            s1_mode_q;
  logic             s1_valid_q;
  logic [A_W-1:0]   s1_a_q;
  logic [SH_W-1:0]  s1_sh_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] acc_q, acc_d;

  logic             s2_hold;
  logic             accept;
  logic             move;
  logic [OUT_W-1:0] cnt_base, cnt_inc;
  logic [OUT_W-1:0] acc_base, acc_new;
  logic [SUM_W-1:0] acc_sum;
  logic             acc_sat;

  assign s2_hold  = out_valid_q && !out_ready;
  assign in_ready = !s1_valid_q || !s2_hold;
  assign accept   = in_valid && in_ready;
  assign move     = s1_valid_q && !s2_hold;

  always_comb begin
    mode_d = M_PASS;
    unique case (1'b1)
      (C < SH_C):                  mode_d = M_CNT;
      (C >= SH_C && C < ACC_C):    mode_d = M_SHIFT;
      (C >= ACC_C && C < PASS_C):  mode_d = M_ACC;
      (C >= PASS_C):               mode_d = M_PASS;
    endcase
  end

  // A beat entering S2 together with clr computes from the cleared state.
  assign cnt_base = clr ? '0 : cnt_q;
  assign acc_base = clr ? '0 : acc_q;
  assign cnt_inc  = cnt_base + OUT_W'(1);
  assign acc_sum  = {1'b0, acc_base} + SUM_W'(s1_a_q);
  assign acc_sat  = acc_sum[OUT_W];
  assign acc_new  = acc_sat ? '1 : acc_sum[OUT_W-1:0];

  always_comb begin
    out_d = '0;
    cnt_d = cnt_base;
    acc_d = acc_base;
    unique case (s1_mode_q)
      M_CNT: begin
        out_d = cnt_inc;
        if (move && !clr) cnt_d = cnt_inc;
      end
      M_SHIFT: out_d = OUT_W'(s1_a_q) << s1_sh_q;
      M_ACC: begin
        out_d = acc_new;
        if (move && !clr) acc_d = acc_new;
      end
      M_PASS: out_d = OUT_W'(s1_a_q);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_sh_q     <= '0;
      s1_mode_q   <= M_CNT;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      if (accept) begin
        s1_valid_q <= 1'b1;
        s1_a_q     <= A;
        s1_sh_q    <= C[SH_W-1:0];
        s1_mode_q  <= mode_d;
      end else if (!s2_hold) begin
        s1_valid_q <= 1'b0;
      end
      if (!s2_hold) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) out_q <= out_d;
      end
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

`ifdef SDP_OVF_FLAG_EN
  logic ovf_q;
  logic ovf_set;

  assign ovf_set = move &&
                   ((s1_mode_q == M_CNT && (&cnt_base)) ||
                    (s1_mode_q == M_ACC && acc_sat));

  // A set event on the same edge as clr keeps the flag raised.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (clr)     ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_sel_datapath_pipe.sv
// tb_sel_datapath_pipe: directed + randomized bench for sel_datapath_pipe.
// A queue-based reference model computes expected results from the band rules.
`timescale 1ns/1ps

module tb_sel_datapath_pipe;

  localparam int A_W   = 10;
  localparam int C_W   = 9;
  localparam int OUT_W = 11;
  localparam int OMAX  = 2047;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   A;
  logic [C_W-1:0]   C;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out;
`ifdef SDP_OVF_FLAG_EN
  logic             ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  int cnt_m, acc_m;
  bit ovf_m;

  int beat_a[$], beat_c[$];
  int obs_out[$], obs_cyc[$], acc_cyc[$], exp_out[$];
  bit obs_ovf[$], exp_ovf[$];
  int stab_bad;

  sel_datapath_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .C         (C),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef SDP_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_clr();
    cnt_m = 0;
    acc_m = 0;
    ovf_m = 1'b0;
  endtask

  task automatic model_beat(input int a, input int c,
                            output int r, output bit o);
    int amt;
    if (c < 51) begin
      cnt_m = (cnt_m + 1) % (OMAX + 1);
      if (cnt_m == 0) ovf_m = 1'b1;
      r = cnt_m;
    end else if (c < 100) begin
      amt = c % 16;
      r = (amt >= OUT_W) ? 0 : ((a << amt) % (OMAX + 1));
    end else if (c < 200) begin
      if (acc_m + a > OMAX) begin
        acc_m = OMAX;
        ovf_m = 1'b1;
      end else begin
        acc_m = acc_m + a;
      end
      r = acc_m;
    end else begin
      r = a;
    end
    o = ovf_m;
  endtask

  task automatic add_beat(input int a, input int c);
    beat_a.push_back(a);
    beat_c.push_back(c);
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clr();
  endtask

  // Drives queued beats, records accepted/delivered beats; no checking here.
  task automatic run_stream(input int rmode, input bit rnd_valid);
    int idx = 0;
    int cyc = 0;
    int n = beat_a.size();
    int lim = n * 12 + 20;
    bit stall_prev = 1'b0;
    logic [OUT_W-1:0] prev = '0;
    int r;
    bit o;
    obs_out.delete(); obs_cyc.delete(); acc_cyc.delete();
    exp_out.delete(); obs_ovf.delete(); exp_ovf.delete();
    stab_bad = 0;
    while (obs_out.size() < n && cyc < lim) begin
      in_valid = (idx < n) && (!rnd_valid || $urandom_range(3) != 0);
      A = (idx < n) ? A_W'(beat_a[idx]) : A_W'($urandom);
      C = (idx < n) ? C_W'(beat_c[idx]) : C_W'($urandom);
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(1));
      endcase
      @(negedge clk);
      if (stall_prev && (!out_valid || out !== prev)) stab_bad++;
      stall_prev = out_valid && !out_ready;
      prev = out;
      if (out_valid && out_ready) begin
        obs_out.push_back(int'(out));
        obs_cyc.push_back(cyc);
`ifdef SDP_OVF_FLAG_EN
        obs_ovf.push_back(ovf);
`else
        obs_ovf.push_back(1'b0);
`endif
      end
      if (in_valid && in_ready) begin
        acc_cyc.push_back(cyc);
        model_beat(beat_a[idx], beat_c[idx], r, o);
        exp_out.push_back(r);
        exp_ovf.push_back(o);
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    beat_a.delete();
    beat_c.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    A = '0; C = '0;
    model_clr();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out !== '0) begin
      n_err++;
      $display("FAIL reset_hold out_valid=%0b out=%0d want 0/0", out_valid, out);
    end
    #4;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready got %0b want 1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid got %0b want 0", out_valid);
    end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 3; i++) add_beat(45, 0);
    run_stream(0, 1'b0);
    n_vec++;
    if (obs_out.size() != 3) begin
      n_err++;
      $display("FAIL cnt_count got %0d beats want 3", obs_out.size());
    end
    for (int i = 0; i < 3 && i < obs_out.size(); i++) begin
      n_vec++;
      if (obs_out[i] != i + 1) begin
        n_err++;
        $display("FAIL cnt_out[%0d] got %0d want %0d", i, obs_out[i], i + 1);
      end
      n_vec++;
      if (obs_cyc[i] - acc_cyc[i] != 2) begin
        n_err++;
        $display("FAIL latency[%0d] got %0d want 2", i, obs_cyc[i] - acc_cyc[i]);
      end
    end
  endtask

  task automatic test_shift();
    int want[3] = '{360, 0, 2040};
    add_beat(45, 67);
    add_beat(45, 75);
    add_beat(1023, 51);
    run_stream(0, 1'b0);
    n_vec++;
    if (obs_out.size() != 3) begin
      n_err++;
      $display("FAIL shift_count got %0d want 3", obs_out.size());
    end
    for (int i = 0; i < 3 && i < obs_out.size(); i++) begin
      n_vec++;
      if (obs_out[i] != want[i]) begin
        n_err++;
        $display("FAIL shift[%0d] got %0d want %0d", i, obs_out[i], want[i]);
      end
    end
  endtask

  task automatic test_acc();
    int want[3] = '{1000, 2000, 2047};
    do_clr();
    for (int i = 0; i < 3; i++) add_beat(1000, 150);
    run_stream(0, 1'b0);
    n_vec++;
    if (obs_out.size() != 3) begin
      n_err++;
      $display("FAIL acc_count got %0d want 3", obs_out.size());
    end
    for (int i = 0; i < 3 && i < obs_out.size(); i++) begin
      n_vec++;
      if (obs_out[i] != want[i]) begin
        n_err++;
        $display("FAIL acc[%0d] got %0d want %0d", i, obs_out[i], want[i]);
      end
`ifdef SDP_OVF_FLAG_EN
      n_vec++;
      if (obs_ovf[i] != (i == 2)) begin
        n_err++;
        $display("FAIL acc_ovf[%0d] got %0b want %0b", i, obs_ovf[i], i == 2);
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 6; i++) add_beat(i, 250);
    run_stream(1, 1'b0);
    n_vec++;
    if (obs_out.size() != 6) begin
      n_err++;
      $display("FAIL bp_count got %0d want 6", obs_out.size());
    end
    for (int i = 0; i < 6 && i < obs_out.size(); i++) begin
      n_vec++;
      if (obs_out[i] != i + 1) begin
        n_err++;
        $display("FAIL bp_out[%0d] got %0d want %0d", i, obs_out[i], i + 1);
      end
    end
    n_vec++;
    if (stab_bad != 0) begin
      n_err++;
      $display("FAIL bp_stable got %0d unstable cycles want 0", stab_bad);
    end
  endtask

  task automatic test_interleave_clr();
    int want[4] = '{1, 5, 2, 10};
    do_clr();
    add_beat(300, 0);
    add_beat(5, 150);
    add_beat(17, 10);
    add_beat(5, 199);
    run_stream(0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (i >= obs_out.size() || obs_out[i] != want[i]) begin
        n_err++;
        $display("FAIL mix[%0d] got %0d want %0d", i,
                 (i < obs_out.size()) ? obs_out[i] : -1, want[i]);
      end
    end
    // CNT beat moves into S2 on the same edge clr is high.
    in_valid = 1'b1; A = 10'd7; C = '0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL clr_accept in_ready got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clr();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out !== 11'd1) begin
      n_err++;
      $display("FAIL clr_same_edge out_valid=%0b out=%0d want 1/1", out_valid, out);
    end
    @(posedge clk); #1;
    add_beat(3, 0);
    add_beat(9, 150);
    run_stream(0, 1'b0);
    n_vec++;
    if (obs_out.size() != 2 || obs_out[0] != 1 || obs_out[1] != 9) begin
      n_err++;
      $display("FAIL clr_state got %0d,%0d want 1,9",
               (obs_out.size() > 0) ? obs_out[0] : -1,
               (obs_out.size() > 1) ? obs_out[1] : -1);
    end
  endtask

  task automatic test_wrap();
    do_clr();
    for (int i = 0; i < 2048; i++) add_beat(i % 1024, i % 51);
    run_stream(0, 1'b0);
    n_vec++;
    if (obs_out.size() != 2048 || obs_out[2046] != 2047 || obs_out[2047] != 0) begin
      n_err++;
      $display("FAIL cnt_wrap got %0d beats last=%0d want 2048 beats last=0",
               obs_out.size(),
               (obs_out.size() == 2048) ? obs_out[2047] : -1);
    end
`ifdef SDP_OVF_FLAG_EN
    n_vec++;
    if (obs_out.size() != 2048 || obs_ovf[2046] != 1'b0 || obs_ovf[2047] != 1'b1) begin
      n_err++;
      $display("FAIL wrap_ovf not raised exactly on the wrapping beat");
    end
`endif
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; A = 10'd5; C = 9'd250;
    @(posedge clk); #1;
    A = 10'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out !== '0) begin
      n_err++;
      $display("FAIL rst_mid out_valid=%0b out=%0d want 0/0", out_valid, out);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    model_clr();
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rst_stale got %0d valid cycles want 0", seen);
    end
    @(posedge clk); #1;
    add_beat(0, 0);
    run_stream(0, 1'b0);
    n_vec++;
    if (obs_out.size() != 1 || obs_out[0] != 1) begin
      n_err++;
      $display("FAIL rst_cnt got %0d want 1", (obs_out.size() > 0) ? obs_out[0] : -1);
    end
  endtask

  task automatic test_random();
    int cb[8] = '{0, 50, 51, 99, 100, 199, 200, 511};
    int a, c;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(7) == 0) ? 1023 : $urandom_range(1023);
      c = ($urandom_range(3) == 0) ? cb[$urandom_range(7)] : $urandom_range(511);
      add_beat(a, c);
    end
    run_stream(2, 1'b1);
    n_vec++;
    if (obs_out.size() != exp_out.size() || obs_out.size() != 300) begin
      n_err++;
      $display("FAIL rnd_count got %0d want %0d", obs_out.size(), exp_out.size());
    end
    for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) begin
      n_vec++;
      if (obs_out[i] != exp_out[i]) begin
        n_err++;
        $display("FAIL rnd_out[%0d] got %0d want %0d", i, obs_out[i], exp_out[i]);
      end
`ifdef SDP_OVF_FLAG_EN
      n_vec++;
      if (obs_ovf[i] != exp_ovf[i]) begin
        n_err++;
        $display("FAIL rnd_ovf[%0d] got %0b want %0b", i, obs_ovf[i], exp_ovf[i]);
      end
`endif
    end
    n_vec++;
    if (stab_bad != 0) begin
      n_err++;
      $display("FAIL rnd_stable got %0d unstable cycles want 0", stab_bad);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_shift();
    test_acc();
    test_backpressure();
    test_interleave_clr();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
